// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared types and constants for the memory request controller
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - fixed-latency valid/ready front end for the single-cycle memory
// Optional: define MEM_REQ_ALIGN_CHK_EN to reject odd byte addresses with resp_err.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  input  logic        halt,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        mem_createdump
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             dump_done_q;
  logic             access;
`ifdef MEM_REQ_ALIGN_CHK_EN
  logic             err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      dump_done_q <= 1'b0;
`ifdef MEM_REQ_ALIGN_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A pending request takes priority; halt is picked up again in DONE.
          if (req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            cnt     <= CNT_LOAD;
`ifdef MEM_REQ_ALIGN_CHK_EN
            err_q   <= req_addr[0];
            if (req_addr[0]) state <= DONE;
            else
`endif
            state <= BUSY;
          end else if (halt) begin
            state <= HALTED;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!wr_q) rdata_q <= mem_data_out;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= halt ? HALTED : IDLE;
        end
        HALTED: begin
          dump_done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset kills the strobe mid-access.
  assign access         = (state == BUSY) && (cnt == '0);
  assign mem_enable     = access;
  assign mem_wr         = access & wr_q;
  assign mem_addr       = addr_q;
  assign mem_data_in    = wdata_q;
  assign mem_createdump = (state == HALTED) && !dump_done_q;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_rdata = resp_valid ? rdata_q : 16'h0000;
`ifdef MEM_REQ_ALIGN_CHK_EN
  assign resp_err   = resp_valid & err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - directed table-driven bench for mem_req_ctrl with LATENCY 4 and 1
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance with a byte-array memory model
  logic        req_valid = 1'b0, req_wr = 1'b0, halt = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_enable, mem_wr, mem_createdump;
  logic [15:0] resp_rdata, mem_addr, mem_data_in, mem_data_out;
  logic [7:0]  mem [0:255] = '{default: 8'h00};

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      mem[mem_addr[7:0]]               <= mem_data_in[15:8];
      mem[8'(mem_addr[7:0] + 8'd1)]    <= mem_data_in[7:0];
    end
  end
  assign mem_data_out = {mem[mem_addr[7:0]], mem[8'(mem_addr[7:0] + 8'd1)]};

  mem_req_ctrl #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .halt(halt),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_createdump(mem_createdump)
  );

  // LATENCY=1 instance with a ROM whose word is addr ^ 16'hA5A5
  logic        req_valid1 = 1'b0;
  logic [15:0] req_addr1 = '0;
  logic        req_ready1, resp_valid1, resp_err1, mem_enable1, mem_wr1, mem_createdump1;
  logic [15:0] resp_rdata1, mem_addr1, mem_data_in1, mem_data_out1;
  assign mem_data_out1 = mem_addr1 ^ 16'hA5A5;

  mem_req_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid1), .req_wr(1'b0), .req_addr(req_addr1), .req_wdata(16'h0000),
    .req_ready(req_ready1), .halt(1'b0),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
    .mem_enable(mem_enable1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1),
    .mem_createdump(mem_createdump1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    halt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one request on the LATENCY=4 instance and observe 12 cycles afterwards.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int halt_at,
                        output int r_cyc, output int r_cnt, output logic [15:0] r_data,
                        output logic r_err, output int e_cnt, output int e_cyc,
                        output logic e_wr, output logic [15:0] e_addr,
                        output int d_cnt, output int d_cyc);
    r_cyc = -1; r_cnt = 0; r_data = '0; r_err = 1'b0;
    e_cnt = 0; e_cyc = -1; e_wr = 1'b0; e_addr = '0; d_cnt = 0; d_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    if (halt_at == 0) halt = 1'b1;
    #1 check("accept_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == halt_at) halt = 1'b1;
      #1;
      if (resp_valid) begin
        r_cnt++;
        if (r_cyc < 0) begin r_cyc = c; r_data = resp_rdata; r_err = resp_err; end
      end
      if (mem_enable) begin
        e_cnt++; e_cyc = c; e_wr = mem_wr; e_addr = mem_addr;
      end
      if (mem_createdump) begin d_cnt++; d_cyc = c; end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_cyc;
    int          exp_en;
  } vec_t;

  vec_t vecs[8];

  int          r_cyc, r_cnt, e_cnt, e_cyc, d_cnt, d_cyc, resp_seen, prev_resp, dbl_resp;
  logic [15:0] r_data, e_addr;
  logic        r_err, e_wr;

  initial begin
    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 5, 1};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 5, 1};
    vecs[2] = '{1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0, 5, 1};
    vecs[3] = '{1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 5, 1};
`ifdef MEM_REQ_ALIGN_CHK_EN
    vecs[4] = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1, 0};
`else
    vecs[4] = '{1'b0, 16'h0011, 16'h0000, 16'hEF00, 1'b0, 5, 1};
`endif
    vecs[5] = '{1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b0, 5, 1};
    vecs[6] = '{1'b1, 16'h00FE, 16'hA5C3, 16'h0000, 1'b0, 5, 1};
    vecs[7] = '{1'b0, 16'h00FE, 16'h0000, 16'hA5C3, 1'b0, 5, 1};

    // Reset values
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_createdump", mem_createdump, 0);
    check("rst_req_ready_l1", req_ready1, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=1 back-to-back reads with req_valid held high
    @(negedge clk);
    req_valid1 = 1'b1; req_addr1 = 16'h0040;
    prev_resp = 0; dbl_resp = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("b2b_ready_%0d", i), req_ready1, (i % 3 == 0) ? 1 : 0);
      check($sformatf("b2b_resp_%0d", i), resp_valid1, (i % 3 == 2) ? 1 : 0);
      if (resp_valid1) begin
        check($sformatf("b2b_rdata_%0d", i), resp_rdata1, 16'hA5E5);
        check($sformatf("b2b_err_%0d", i), resp_err1, 0);
      end
      if (resp_valid1 && prev_resp != 0) dbl_resp++;
      prev_resp = resp_valid1 ? 1 : 0;
    end
    check("b2b_no_double_resp", dbl_resp, 0);
    req_valid1 = 1'b0;
    do_reset();

    // Table-driven single requests on the LATENCY=4 instance
    for (int v = 0; v < 8; v++) begin
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, -1,
             r_cyc, r_cnt, r_data, r_err, e_cnt, e_cyc, e_wr, e_addr, d_cnt, d_cyc);
      check($sformatf("v%0d_resp_cycle", v), r_cyc, vecs[v].exp_cyc);
      check($sformatf("v%0d_resp_count", v), r_cnt, 1);
      check($sformatf("v%0d_rdata", v), r_data, vecs[v].exp_data);
      check($sformatf("v%0d_err", v), r_err, vecs[v].exp_err);
      check($sformatf("v%0d_enable_count", v), e_cnt, vecs[v].exp_en);
      if (vecs[v].exp_en != 0) begin
        check($sformatf("v%0d_access_cycle", v), e_cyc, 4);
        check($sformatf("v%0d_access_wr", v), e_wr, vecs[v].wr);
        check($sformatf("v%0d_access_addr", v), e_addr, vecs[v].addr);
      end
    end

    // Reset in BUSY with cnt=2 during a write
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'h5555;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_rdata", resp_rdata, 0);
    check("midrst_mem_enable", mem_enable, 0);
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_data_in", mem_data_in, 0);
    check("midrst_createdump", mem_createdump, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 if (resp_valid || mem_enable) resp_seen++;
    end
    check("midrst_no_resp", resp_seen, 0);
    do_req(1'b0, 16'h0010, 16'h0000, -1,
           r_cyc, r_cnt, r_data, r_err, e_cnt, e_cyc, e_wr, e_addr, d_cnt, d_cyc);
    check("midrst_old_data", r_data, 16'hBEEF);

    // Reset during the access cycle of a write
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h9999;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (4) @(negedge clk);
    #1 check("acc_enable_before_rst", mem_enable, 1);
    rst_n = 1'b0;
    #1 check("acc_enable_after_rst", mem_enable, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 16'h0020, 16'h0000, -1,
           r_cyc, r_cnt, r_data, r_err, e_cnt, e_cyc, e_wr, e_addr, d_cnt, d_cyc);
    check("acc_rst_old_data", r_data, 16'h1234);

    // halt raised while BUSY and held
    do_req(1'b0, 16'h0020, 16'h0000, 2,
           r_cyc, r_cnt, r_data, r_err, e_cnt, e_cyc, e_wr, e_addr, d_cnt, d_cyc);
    check("hbusy_resp_cycle", r_cyc, 5);
    check("hbusy_rdata", r_data, 16'h1234);
    check("hbusy_dump_count", d_cnt, 1);
    check("hbusy_dump_cycle", d_cyc, 6);
    req_valid = 1'b1; req_addr = 16'h0010;
    resp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 if (req_ready || mem_enable || resp_valid || mem_createdump) resp_seen++;
    end
    check("hbusy_stays_halted", resp_seen, 0);
    req_valid = 1'b0;
    do_reset();

    // halt and req_valid together in IDLE
    do_req(1'b0, 16'h0010, 16'h0000, 0,
           r_cyc, r_cnt, r_data, r_err, e_cnt, e_cyc, e_wr, e_addr, d_cnt, d_cyc);
    check("hboth_resp_cycle", r_cyc, 5);
    check("hboth_rdata", r_data, 16'hBEEF);
    check("hboth_dump_count", d_cnt, 1);
    check("hboth_dump_cycle", d_cyc, 6);
    do_reset();

    // halt alone in IDLE
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    #1 check("hidle_dump", mem_createdump, 1);
    @(negedge clk);
    #1 check("hidle_dump_once", mem_createdump, 0);
    check("hidle_not_ready", req_ready, 0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Multi-cycle request controller placed directly upstream of the single-cycle byte-addressable memory. It gives the fetch or memory pipeline stage a valid/ready request interface and a one-cycle response pulse. It models a fixed access latency with a down-counter and drives the memory's enable, write, address and write-data ports for exactly one cycle per access. It also checks word alignment and sequences the end-of-program memory dump.

## Interface
- LATENCY, default 4: cycles from request acceptance to the memory access cycle, inclusive; legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  16  byte address.
- req_wdata  in  16  write data, big-endian: [15:8] goes to the byte at addr.
- req_ready  out  1  controller can accept a request this cycle.
- halt  in  1  program finished; request a memory dump.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  16  read data; 0 for writes and for errors.
- resp_err  out  1  misaligned request; valid only with resp_valid.
- mem_enable  out  1  to memory enable.
- mem_wr  out  1  to memory wr.
- mem_addr  out  16  to memory addr.
- mem_data_in  out  16  to memory data_in.
- mem_data_out  in  16  from memory data_out; combinational read.
- mem_createdump  out  1  to memory createdump.

## Operation
- The FSM has four states: IDLE, BUSY, DONE and HALTED.
- IDLE behaviour:
  - req_ready=1.
  - If req_valid is high, the controller latches wr, addr and wdata and loads cnt=LATENCY-1.
  - If a misaligned request is detected (addr[0]=1, see Configuration), the next state is DONE with err_q=1 and no memory access occurs.
  - Otherwise the next state is BUSY.
  - If halt=1 and req_valid=0, the next state is HALTED.
  - If halt and req_valid are both high, the request wins and halt is honoured after the response.
- BUSY behaviour:
  - req_ready=0.
  - While cnt>0, cnt decrements each cycle.
  - When cnt==0, this is the access cycle: mem_enable=1 and mem_wr=wr_q. On a read, mem_data_out is captured into rdata_q at that edge. On a write, the memory writes at that edge.
  - The next state is DONE.
- DONE behaviour:
  - resp_valid=1, resp_rdata=rdata_q (0 for writes and errors), resp_err=err_q.
  - The next state is IDLE. If halt=1, the next state is HALTED instead.
- HALTED behaviour:
  - mem_createdump=1 for exactly the first cycle in this state.
  - req_ready=0 and all mem_* strobes are 0.
  - The controller stays in HALTED until reset.
- mem_addr and mem_data_in always reflect the latched addr_q and wdata_q. mem_enable and mem_wr are 0 outside the access cycle.
- Requests are non-pipelined. There is at most one request outstanding.
- cnt width is 4 bits.

## Timing
- Reset values of all outputs:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0, mem_createdump=0.
  - State is IDLE and all internal registers are 0.
- Latency for a normal request:
  - The request is accepted at edge 0.
  - The access cycle is cycle LATENCY.
  - resp_valid is high in cycle LATENCY+1.
  - The next acceptance can occur in cycle LATENCY+2.
- With LATENCY=1, the cycle after acceptance is the access cycle.
- A misaligned request produces resp_valid in cycle 1 after acceptance.
- Reset asserted mid-request:
  - Before the access cycle: no memory write occurs and no response is produced.
  - During the access cycle: the combinational mem_enable drops immediately, so no write occurs.
- req_* inputs are ignored outside IDLE.
- halt arriving in BUSY is not lost if it is still asserted in DONE. halt is level-sensitive and is sampled only in IDLE and DONE.

## Configuration
- MEM_REQ_ALIGN_CHK_EN defined:
  - A request with req_addr[0]=1 is rejected.
  - The response has resp_err=1 and resp_rdata=0.
  - The memory is never enabled for that request.
- MEM_REQ_ALIGN_CHK_EN undefined:
  - All addresses go to memory unmodified.
  - resp_err is tied to 0.
  - The DONE-with-error path is not generated.

## Structure
- Package mem_req_pkg holds:
  - the state enum {IDLE, BUSY, DONE, HALTED} in 2 bits;
  - the constants MAX_LATENCY=15 and CNT_W=4.
- The FSM, latency counter and capture registers live in one module. No sub-module is natural.
- The memory is instantiated beside this controller at the stage top. It is not instantiated inside this controller.

## Test plan
- LATENCY=4 write: addr=0x0010, wdata=0xBEEF. Required: mem_enable and mem_wr high only in cycle 4; resp_valid in cycle 5 with rdata=0. A following read of 0x0010 returns resp_rdata=0xBEEF.
- LATENCY=1 back-to-back reads with req_valid held high:
  - req_ready=0 for 2 cycles after each acceptance.
  - Each response arrives 2 cycles after its acceptance.
  - resp_valid never stays high for 2 consecutive cycles.
- Misaligned read at addr=0x0011 with the macro defined: resp_valid in cycle 1 with resp_err=1, rdata=0, and mem_enable never high. With the macro undefined: normal access and resp_err=0.
- Reset asserted during a write in BUSY with cnt=2:
  - All outputs return to their reset values asynchronously.
  - A later read of the same address returns the old data.
  - No resp_valid is produced.
- halt raised during a BUSY read and held: the response completes, then mem_createdump is high for exactly one cycle, then req_ready=0 permanently.
- Simultaneous halt and req_valid in IDLE: the request is served first, then the dump pulse occurs in the cycle after resp_valid.
